// File: rtl/ir_cmd_pkg.sv
// Shared definitions for the IR command sequencer: frame fields, opcodes,
// motor direction encoding, FSM states and the opcode-to-direction map.
package ir_cmd_pkg;

   localparam logic [3:0] MARKER    = 4'h5;

   localparam logic [3:0] OP_STOP   = 4'd0;
   localparam logic [3:0] OP_FWD    = 4'd1;
   localparam logic [3:0] OP_REV    = 4'd2;
   localparam logic [3:0] OP_SPIN_L = 4'd3;
   localparam logic [3:0] OP_SPIN_R = 4'd4;

   localparam logic [1:0] DIR_STOP  = 2'b00;
   localparam logic [1:0] DIR_FWD   = 2'b01;
   localparam logic [1:0] DIR_REV   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   // Returns {left, right}; unknown opcodes map to a full stop.
   function automatic logic [3:0] op_to_dir(input logic [3:0] op);
      logic [3:0] dir;
      case (op)
         OP_FWD:    dir = {DIR_FWD,  DIR_FWD};
         OP_REV:    dir = {DIR_REV,  DIR_REV};
         OP_SPIN_L: dir = {DIR_REV,  DIR_FWD};
         OP_SPIN_R: dir = {DIR_FWD,  DIR_REV};
         default:   dir = {DIR_STOP, DIR_STOP};
      endcase
      return dir;
   endfunction

   function automatic logic dir_reverses(input logic [1:0] from_dir,
                                         input logic [1:0] to_dir);
      return ((from_dir == DIR_FWD) && (to_dir == DIR_REV)) ||
             ((from_dir == DIR_REV) && (to_dir == DIR_FWD));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ir_cmd_timer.sv
// Loadable down-counter with freeze; stops at zero and flags it.
module ir_cmd_timer #(
   parameter int W = 8
) (
   input  logic         clk80,
   input  logic         reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_freeze,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk80 or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (!i_freeze && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// IR command sequencer: decodes receiver bytes into left/right motor drive,
// with a refresh watchdog and optional reversal dead-time (IR_CMD_DEADTIME_EN).
//
//   state | meaning
//   IDLE  | motors stopped, waiting for a non-stop command
//   RUN   | applied directions driven, watchdog counting
//   DEAD  | motors off during reversal, pending target held, watchdog frozen
import ir_cmd_pkg::*;

module ir_cmd_ctrl #(
   parameter int TIMEOUT_CYCLES = 16_000_000,
   parameter int DEAD_CYCLES    = 4000
) (
   input  logic       clk80,
   input  logic       reset_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic [1:0] motor_l,
   output logic [1:0] motor_r,
   output logic       active,
   output logic       cmd_err,
   output logic       timeout
);

   // Both timers share one width so either period fits.
   localparam int              CNT_W     = $clog2(max_int(TIMEOUT_CYCLES, DEAD_CYCLES));
   localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_mot;
   logic [3:0] w_mot_nxt;
   logic       r_cmd_err;
   logic       w_cmd_err_nxt;
   logic       r_timeout;
   logic       w_timeout_nxt;

   logic [3:0] w_op;
   logic [3:0] w_tgt;
   logic       w_valid;
   logic       w_go;
   logic       w_stop;
   logic       w_defer;

   logic       w_wd_load;
   logic       w_wd_zero;

   assign w_op    = rx_byte[7:4];
   assign w_valid = rx_valid && (rx_byte[3:0] == MARKER) && (w_op <= OP_SPIN_R);
   assign w_tgt   = op_to_dir(w_op);
   assign w_go    = w_valid && (w_op != OP_STOP);
   assign w_stop  = w_valid && (w_op == OP_STOP);

   ir_cmd_timer #(.W(CNT_W)) u_wd (
      .clk80      (clk80),
      .reset_n    (reset_n),
      .i_load     (w_wd_load),
      .i_load_val (WD_LOAD),
      .i_freeze   (r_state != ST_RUN),
      .o_zero     (w_wd_zero)
   );

`ifdef IR_CMD_DEADTIME_EN
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

   logic [3:0] r_pend;
   logic [3:0] w_pend_nxt;
   logic       w_dd_load;
   logic       w_dd_zero;

   ir_cmd_timer #(.W(CNT_W)) u_dead (
      .clk80      (clk80),
      .reset_n    (reset_n),
      .i_load     (w_dd_load),
      .i_load_val (DEAD_LOAD),
      .i_freeze   (r_state != ST_DEAD),
      .o_zero     (w_dd_zero)
   );

   // Reversal is only judged in RUN, where r_mot holds the applied directions.
   assign w_defer = dir_reverses(r_mot[3:2], w_tgt[3:2]) ||
                    dir_reverses(r_mot[1:0], w_tgt[1:0]);

   always_ff @(posedge clk80 or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end
`else
   assign w_defer = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_mot_nxt     = r_mot;
      w_cmd_err_nxt = rx_valid && !w_valid;
      w_timeout_nxt = 1'b0;
      w_wd_load     = 1'b0;
`ifdef IR_CMD_DEADTIME_EN
      w_pend_nxt    = r_pend;
      w_dd_load     = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_go) begin
               w_state_nxt = ST_RUN;
               w_mot_nxt   = w_tgt;
               w_wd_load   = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_stop) begin
               w_state_nxt = ST_IDLE;
               w_mot_nxt   = '0;
            end else if (w_go && !w_defer) begin
               w_mot_nxt   = w_tgt;
               w_wd_load   = 1'b1;
`ifdef IR_CMD_DEADTIME_EN
            end else if (w_go) begin
               w_state_nxt = ST_DEAD;
               w_mot_nxt   = '0;
               w_pend_nxt  = w_tgt;
               w_dd_load   = 1'b1;
`endif
            end else if (w_wd_zero) begin
               // A command landing on the expiry cycle is handled above and wins.
               w_state_nxt   = ST_IDLE;
               w_mot_nxt     = '0;
               w_timeout_nxt = 1'b1;
            end
         end
`ifdef IR_CMD_DEADTIME_EN
         ST_DEAD: begin
            if (w_stop) begin
               w_state_nxt = ST_IDLE;
               w_mot_nxt   = '0;
            end else if (w_dd_zero) begin
               // Dead-time has fully elapsed, so a command arriving now is applied as-is.
               w_state_nxt = ST_RUN;
               w_mot_nxt   = w_go ? w_tgt : r_pend;
               w_wd_load   = 1'b1;
            end else if (w_go) begin
               w_pend_nxt  = w_tgt;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
            w_mot_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk80 or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_mot     <= '0;
         r_cmd_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mot     <= w_mot_nxt;
         r_cmd_err <= w_cmd_err_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign motor_l = r_mot[3:2];
   assign motor_r = r_mot[1:0];
   assign active  = (r_state != ST_IDLE);
   assign cmd_err = r_cmd_err;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// Self-checking bench for ir_cmd_ctrl: directed table, multi-cycle corner
// sequences and randomized traffic against a deadline-based reference model.
module tb_ir_cmd_ctrl;

   localparam int T = 100;
   localparam int D = 10;
`ifdef IR_CMD_DEADTIME_EN
   localparam bit DEAD_EN = 1'b1;
`else
   localparam bit DEAD_EN = 1'b0;
`endif

   logic       clk80 = 1'b0;
   logic       reset_n;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic [1:0] motor_l;
   logic [1:0] motor_r;
   logic       active;
   logic       cmd_err;
   logic       timeout;

   always #5 clk80 = ~clk80;

   ir_cmd_ctrl #(.TIMEOUT_CYCLES(T), .DEAD_CYCLES(D)) dut (
      .clk80    (clk80),
      .reset_n  (reset_n),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .motor_l  (motor_l),
      .motor_r  (motor_r),
      .active   (active),
      .cmd_err  (cmd_err),
      .timeout  (timeout)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 dead; timers kept as absolute deadlines.
   logic [3:0] lut [5];
   int         m_mode;
   int         m_n;
   int         m_wd_due;
   int         m_dead_due;
   logic [3:0] m_app;
   logic [3:0] m_pend;
   logic       m_err;
   logic       m_to;

   typedef struct {
      logic       v;
      logic [7:0] b;
      logic [3:0] mot;
      logic       act;
      logic       err;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit reverses(input logic [1:0] a, input logic [1:0] t);
      return (a != 2'b00) && (t != 2'b00) && (a != t);
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_app  = '0;
      m_pend = '0;
      m_err  = 1'b0;
      m_to   = 1'b0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] b);
      bit         ok;
      bit         go;
      bit         stp;
      logic [3:0] t;
      m_n++;
      m_to  = 1'b0;
      ok    = v && (b[3:0] == 4'h5) && (b[7:4] <= 4'd4);
      m_err = v && !ok;
      t     = ok ? lut[int'(b[7:4])] : 4'h0;
      stp   = ok && (b[7:4] == 4'd0);
      go    = ok && !stp;
      case (m_mode)
         0: if (go) begin
               m_mode = 1; m_app = t; m_wd_due = m_n + T;
            end
         1: begin
            if (stp) m_mode = 0;
            else if (go) begin
               if (DEAD_EN && (reverses(m_app[3:2], t[3:2]) || reverses(m_app[1:0], t[1:0]))) begin
                  m_mode = 2; m_pend = t; m_dead_due = m_n + D;
               end else begin
                  m_app = t; m_wd_due = m_n + T;
               end
            end else if (m_n == m_wd_due) begin
               m_mode = 0; m_to = 1'b1;
            end
         end
         default: begin
            if (stp) m_mode = 0;
            else if (m_n == m_dead_due) begin
               m_mode = 1; m_app = go ? t : m_pend; m_wd_due = m_n + T;
            end else if (go) m_pend = t;
         end
      endcase
   endtask

   task automatic step(input logic v, input logic [7:0] b);
      logic [3:0] em;
      @(negedge clk80);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk80);
      model_edge(v, b);
      #1;
      em = (m_mode == 1) ? m_app : 4'h0;
      chk("motor_l", 32'(motor_l), 32'(em[3:2]));
      chk("motor_r", 32'(motor_r), 32'(em[1:0]));
      chk("active",  32'(active),  32'(m_mode != 0));
      chk("cmd_err", 32'(cmd_err), 32'(m_err));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   task automatic rst_mid();
      @(negedge clk80);
      #2;
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      #1;
      chk("rst_motor_l", 32'(motor_l), 32'h0);
      chk("rst_motor_r", 32'(motor_r), 32'h0);
      chk("rst_active",  32'(active),  32'h0);
      chk("rst_cmd_err", 32'(cmd_err), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      model_reset();
      @(negedge clk80);
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit reached");
      $fatal(1);
   end

   initial begin
      int a;
      int e;
      int nto;
      int first_to;
      int zeros;
      bit got;

      lut = '{4'b0000, 4'b0101, 4'b1010, 4'b1001, 4'b0110};
      tbl = '{
         '{1'b1, 8'h15, 4'b0101, 1'b1, 1'b0},
         '{1'b0, 8'h15, 4'b0101, 1'b1, 1'b0},
         '{1'b1, 8'h16, 4'b0101, 1'b1, 1'b1},
         '{1'b1, 8'h75, 4'b0101, 1'b1, 1'b1},
         '{1'b1, 8'h15, 4'b0101, 1'b1, 1'b0},
         '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0},
         '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0},
         '{1'b1, 8'h25, 4'b1010, 1'b1, 1'b0},
         '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0},
         '{1'b1, 8'h35, 4'b1001, 1'b1, 1'b0},
         '{1'b1, 8'hF5, 4'b1001, 1'b1, 1'b1},
         '{1'b1, 8'h55, 4'b1001, 1'b1, 1'b1},
         '{1'b1, 8'h4A, 4'b1001, 1'b1, 1'b1},
         '{1'b1, 8'h35, 4'b1001, 1'b1, 1'b0},
         '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0},
         '{1'b1, 8'h45, 4'b0110, 1'b1, 1'b0},
         '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0}
      };

      m_n = 0;
      m_wd_due = 0;
      m_dead_due = 0;
      model_reset();
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (2) @(negedge clk80);
      chk("reset_motors", 32'({motor_l, motor_r}), 32'h0);
      chk("reset_active", 32'(active), 32'h0);
      chk("reset_pulses", 32'({cmd_err, timeout}), 32'h0);
      reset_n = 1'b1;

      // Directed table, no reversal from RUN so it holds with or without dead-time.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].v, tbl[i].b);
         chk($sformatf("tbl%0d_motors", i), 32'({motor_l, motor_r}), 32'(tbl[i].mot));
         chk($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].act));
         chk($sformatf("tbl%0d_cmd_err", i), 32'(cmd_err), 32'(tbl[i].err));
      end

      // Watchdog expiry with no refresh.
      step(1'b1, 8'h15);
      a = m_n;
      nto = 0;
      first_to = -1;
      for (int i = 0; i < 150; i++) begin
         step(1'b0, 8'h00);
         if (timeout === 1'b1) begin
            nto++;
            if (first_to < 0) first_to = m_n - a;
         end
      end
      chk("timeout_count", 32'(nto), 32'd1);
      chk("timeout_offset", 32'(first_to), 32'(T));

      // Full reversal: dead-time length before 10/10 appears.
      step(1'b1, 8'h15);
      repeat (5) step(1'b0, 8'h00);
      step(1'b1, 8'h25);
      zeros = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if ({motor_l, motor_r} === 4'b1010) got = 1'b1;
         else begin
            zeros++;
            step(1'b0, 8'h00);
         end
      end
      chk("reverse_seen", 32'(got), 32'd1);
      chk("dead_length", 32'(zeros), DEAD_EN ? 32'(D) : 32'd0);
      step(1'b1, 8'h05);

      // Pending replaced mid-dead; the dead interval keeps its original end.
      step(1'b1, 8'h15);
      repeat (3) step(1'b0, 8'h00);
      step(1'b1, 8'h25);
      e = m_n;
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'h35);
      for (int i = 0; i < D - 3; i++) step(1'b0, 8'h00);
      chk("pend_edge", 32'(m_n - e), 32'(D));
      chk("pend_motors", 32'({motor_l, motor_r}), 32'b1001);
      step(1'b1, 8'h05);

      // Refresh every 90 cycles keeps the watchdog from firing.
      step(1'b1, 8'h15);
      nto = 0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 89; i++) begin
            step(1'b0, 8'h00);
            if (timeout === 1'b1) nto++;
         end
         step(1'b1, 8'h15);
         if (timeout === 1'b1) nto++;
      end
      chk("refresh_no_timeout", 32'(nto), 32'd0);
      step(1'b1, 8'h05);

      // Stop on the expiry cycle.
      step(1'b1, 8'h15);
      repeat (99) step(1'b0, 8'h00);
      step(1'b1, 8'h05);
      chk("expiry_stop_timeout", 32'(timeout), 32'd0);
      chk("expiry_stop_active", 32'(active), 32'd0);

      // Refresh on the expiry cycle reloads the watchdog.
      step(1'b1, 8'h15);
      repeat (99) step(1'b0, 8'h00);
      step(1'b1, 8'h15);
      chk("expiry_run_timeout", 32'(timeout), 32'd0);
      chk("expiry_run_motors", 32'({motor_l, motor_r}), 32'b0101);
      repeat (99) step(1'b0, 8'h00);
      chk("expiry_run_hold", 32'({motor_l, motor_r}), 32'b0101);
      step(1'b0, 8'h00);
      chk("expiry_run_timeout2", 32'(timeout), 32'd1);

      // Reset mid-RUN and mid-DEAD.
      step(1'b1, 8'h15);
      step(1'b0, 8'h00);
      rst_mid();
      step(1'b0, 8'h00);
      chk("rst_run_idle", 32'(active), 32'd0);
      step(1'b1, 8'h15);
      step(1'b1, 8'h25);
      rst_mid();
      repeat (15) step(1'b0, 8'h00);
      chk("rst_dead_dropped", 32'({motor_l, motor_r, active}), 32'd0);

      // Randomized traffic with alternating dense and sparse phases.
      for (int c = 0; c < 20; c++) begin
         int den;
         den = (c % 2 == 0) ? 4 : 150;
         for (int i = 0; i < 200; i++) begin
            logic       v;
            logic [7:0] b;
            v = ($urandom_range(0, den - 1) == 0);
            if ($urandom_range(0, 9) < 7) b = {4'($urandom_range(0, 4)), 4'h5};
            else b = 8'($urandom);
            step(v, b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
